// File: rtl/vga_scene_renderer.sv
// VGA raster timing plus a Flappy-style scene renderer (bird, pipes, sky).
// Scene inputs are latched once per frame at the start of vertical blanking.
module vga_scene_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_DIV    = 4,
  parameter int NUM_PIPES  = 3,
  parameter int PIPE_W     = 52,
  parameter int GAP_H      = 100,
  parameter int BIRD_SIZE  = 16,
  parameter int COLOR_BITS = 4
) (
  input  logic                    ClkPort,
  input  logic                    reset,
  input  logic [9:0]              bird_x,
  input  logic [9:0]              bird_y,
  input  logic [10*NUM_PIPES-1:0] pipe_x,
  input  logic [10*NUM_PIPES-1:0] pipe_gap_y,
  input  logic [NUM_PIPES-1:0]    pipe_en,
  output logic                    vga_h_sync,
  output logic                    vga_v_sync,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    frame_tick,
  output logic [9:0]              CounterX,
  output logic [9:0]              CounterY
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_PRE_BLK  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [COLOR_BITS-1:0] C_MAX  = {COLOR_BITS{1'b1}};
  localparam logic [COLOR_BITS-1:0] C_HALF = C_MAX >> 1;
  localparam logic [COLOR_BITS-1:0] C_ZERO = '0;

  logic [DIV_W-1:0]        divider;
  logic                    pixCe;
  logic                    lineEnd;
  logic                    frameStart;

  logic [9:0]              birdXS;
  logic [9:0]              birdYS;
  logic [10*NUM_PIPES-1:0] pipeXS;
  logic [10*NUM_PIPES-1:0] pipeGapS;
  logic [NUM_PIPES-1:0]    pipeEnS;

  logic                    birdHit;
  logic                    pipeHit;
  logic                    activeArea;
  logic                    hSyncRaw;
  logic                    vSyncRaw;

  logic                    birdHit_p1;
  logic                    pipeHit_p1;
  logic                    vld_p1;
  logic                    hSync_p1;
  logic                    vSync_p1;

  // Span test with an 11-bit end so objects near column/line 1023 never wrap to 0.
  function automatic logic inSpan(input logic [9:0] pos, input logic [9:0] start,
                                  input int unsigned len);
    logic [10:0] last;
    last = {1'b0, start} + 11'(len) - 11'd1;
    return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} <= last);
  endfunction

  function automatic logic [3*COLOR_BITS-1:0] pickColor(input logic vld, input logic bird,
                                                        input logic pipe);
    if (!vld)      return {C_ZERO, C_ZERO, C_ZERO};
    else if (bird) return {C_MAX, C_MAX, C_ZERO};
    else if (pipe) return {C_ZERO, C_MAX, C_ZERO};
    else           return {C_ZERO, C_HALF, C_MAX};
  endfunction

  assign pixCe      = (divider == DIV_W'(PIX_DIV - 1));
  assign lineEnd    = (CounterX == H_LAST);
  assign frameStart = lineEnd && (CounterY == V_PRE_BLK);

  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset)     divider <= '0;
    else if (pixCe) divider <= '0;
    else            divider <= divider + DIV_W'(1);
  end

  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      CounterX   <= '0;
      CounterY   <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pixCe && frameStart;
      if (pixCe) begin
        if (lineEnd) begin
          CounterX <= '0;
          CounterY <= (CounterY == V_LAST) ? 10'd0 : CounterY + 10'd1;
        end else begin
          CounterX <= CounterX + 10'd1;
        end
      end
    end
  end

  // Scene shadow: loaded on the edge that enters vertical blanking.
  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      birdXS   <= '0;
      birdYS   <= '0;
      pipeXS   <= '0;
      pipeGapS <= '0;
      pipeEnS  <= '0;
    end else if (pixCe && frameStart) begin
      birdXS   <= bird_x;
      birdYS   <= bird_y;
      pipeXS   <= pipe_x;
      pipeGapS <= pipe_gap_y;
      pipeEnS  <= pipe_en;
    end
  end

  always_comb begin
    birdHit = inSpan(CounterX, birdXS, BIRD_SIZE) && inSpan(CounterY, birdYS, BIRD_SIZE);
    pipeHit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pipeEnS[i] && inSpan(CounterX, pipeXS[10*i +: 10], PIPE_W) &&
          !inSpan(CounterY, pipeGapS[10*i +: 10], GAP_H))
        pipeHit = 1'b1;
    end
    activeArea = (CounterX < H_ACT_END) && (CounterY < V_ACT_END);
    hSyncRaw   = !((CounterX >= HS_START) && (CounterX <= HS_END));
    vSyncRaw   = !((CounterY >= VS_START) && (CounterY <= VS_END));
  end

  // Stage 1: hit tests, display enable and raw syncs.
  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      birdHit_p1 <= 1'b0;
      pipeHit_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      hSync_p1   <= 1'b1;
      vSync_p1   <= 1'b1;
    end else if (pixCe) begin
      birdHit_p1 <= birdHit;
      pipeHit_p1 <= pipeHit;
      vld_p1     <= activeArea;
      hSync_p1   <= hSyncRaw;
      vSync_p1   <= vSyncRaw;
    end
  end

  // Stage 2: colour resolve and sync outputs, kept aligned.
  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else if (pixCe) begin
      {vga_r, vga_g, vga_b} <= pickColor(vld_p1, birdHit_p1, pipeHit_p1);
      vga_h_sync            <= hSync_p1;
      vga_v_sync            <= vSync_p1;
    end
  end

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Scoreboard bench for vga_scene_renderer on a shrunken raster; a pixel-level
// reference model predicts every output pixel, sync level and frame tick.
module tb_vga_scene_renderer;

  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam int PIX_DIV = 2, NP = 3, PIPE_W = 6, GAP_H = 6, BIRD_SIZE = 4, CB = 4;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CYC = H_TOTAL * V_TOTAL * PIX_DIV;
  localparam int M = (1 << CB) - 1;

  logic ClkPort = 1'b0;
  logic reset = 1'b1;
  logic [9:0] bird_x = '0, bird_y = '0;
  logic [10*NP-1:0] pipe_x = '0, pipe_gap_y = '0;
  logic [NP-1:0] pipe_en = '0;
  logic vga_h_sync, vga_v_sync, frame_tick;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic [9:0] CounterX, CounterY;

  vga_scene_renderer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV), .NUM_PIPES(NP), .PIPE_W(PIPE_W), .GAP_H(GAP_H),
    .BIRD_SIZE(BIRD_SIZE), .COLOR_BITS(CB)
  ) dut (
    .ClkPort(ClkPort), .reset(reset), .bird_x(bird_x), .bird_y(bird_y),
    .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .pipe_en(pipe_en),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick),
    .CounterX(CounterX), .CounterY(CounterY)
  );

  always #5 ClkPort = ~ClkPort;

  typedef struct {
    logic [CB-1:0] r, g, b;
    logic          hs, vs;
  } outExp_t;

  typedef struct {
    int x, y;
    bit tick;
  } ctrExp_t;

  outExp_t outQ[$];
  ctrExp_t ctrQ[$];
  int checks = 0;
  int fails = 0;

  // Scene currently presented on the inputs, and the model's latched copy.
  int inBx, inBy, inPx[NP], inGy[NP];
  bit inEn[NP];
  int shBx, shBy, shPx[NP], shGy[NP];
  bit shEn[NP];

  int k = 0;  // ClkPort edges since reset release
  int n = 0;  // pixel periods since reset release

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic outExp_t expectPixel(input int x, input int y);
    outExp_t e;
    bit bird, pipe;
    e.hs = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
    e.vs = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
    e.r = 0; e.g = 0; e.b = 0;
    if (x < H_ACTIVE && y < V_ACTIVE) begin
      bird = (x >= shBx) && (x < shBx + BIRD_SIZE) && (y >= shBy) && (y < shBy + BIRD_SIZE);
      pipe = 0;
      for (int i = 0; i < NP; i++)
        if (shEn[i] && x >= shPx[i] && x < shPx[i] + PIPE_W &&
            !(y >= shGy[i] && y < shGy[i] + GAP_H))
          pipe = 1;
      if (bird)      begin e.r = CB'(M); e.g = CB'(M);     e.b = 0;      end
      else if (pipe) begin e.r = 0;      e.g = CB'(M);     e.b = 0;      end
      else           begin e.r = 0;      e.g = CB'(M / 2); e.b = CB'(M); end
    end
    return e;
  endfunction

  task automatic driveInputs();
    bird_x = 10'(inBx);
    bird_y = 10'(inBy);
    for (int i = 0; i < NP; i++) begin
      pipe_x[10*i +: 10]     = 10'(inPx[i]);
      pipe_gap_y[10*i +: 10] = 10'(inGy[i]);
      pipe_en[i]             = inEn[i];
    end
  endtask

  task automatic setScene(input int bx, input int by, input int p0, input int g0, input bit e0,
                          input int p1, input int g1, input bit e1,
                          input int p2, input int g2, input bit e2);
    inBx = bx; inBy = by;
    inPx[0] = p0; inGy[0] = g0; inEn[0] = e0;
    inPx[1] = p1; inGy[1] = g1; inEn[1] = e1;
    inPx[2] = p2; inGy[2] = g2; inEn[2] = e2;
    driveInputs();
  endtask

  function automatic int randCoord(input int hi);
    if ($urandom_range(0, 7) == 0) return $urandom_range(1000, 1023);
    return $urandom_range(0, hi);
  endfunction

  task automatic randScene();
    inBx = randCoord(H_ACTIVE + 4);
    inBy = randCoord(V_ACTIVE + 4);
    for (int i = 0; i < NP; i++) begin
      inPx[i] = randCoord(H_ACTIVE + 2);
      inGy[i] = randCoord(V_ACTIVE);
      inEn[i] = $urandom_range(0, 1);
    end
    driveInputs();
  endtask

  // Called once per falling edge: predicts what the following rising edge does.
  task automatic modelStep();
    int x, y, nx, ny;
    ctrExp_t c;
    if (k % PIX_DIV == PIX_DIV - 1) begin
      x = n % H_TOTAL;
      y = (n / H_TOTAL) % V_TOTAL;
      outQ.push_back(expectPixel(x, y));
      nx = (n + 1) % H_TOTAL;
      ny = ((n + 1) / H_TOTAL) % V_TOTAL;
      c.x = nx; c.y = ny; c.tick = (nx == 0 && ny == V_ACTIVE);
      ctrQ.push_back(c);
      if (c.tick) begin
        shBx = inBx; shBy = inBy;
        for (int i = 0; i < NP; i++) begin
          shPx[i] = inPx[i]; shGy[i] = inGy[i]; shEn[i] = inEn[i];
        end
      end
      n++;
    end
    k++;
  endtask

  task automatic runCycles(input int cycles, input bit randomize);
    for (int c = 0; c < cycles; c++) begin
      @(negedge ClkPort);
      if (randomize && $urandom_range(0, 599) == 0) randScene();
      modelStep();
    end
  endtask

  task automatic runUntilLine(input int line);
    int budget;
    budget = 2 * FRAME_CYC;
    while (((n / H_TOTAL) % V_TOTAL) != line && budget > 0) begin
      runCycles(1, 0);
      budget--;
    end
    check("reach_line", 32'(budget > 0), 32'd1);
  endtask

  task automatic resetDut();
    outExp_t idle;
    @(negedge ClkPort);
    #2;
    reset = 1'b0;
    #1;
    check("rst_hs", 32'(vga_h_sync), 32'd1);
    check("rst_vs", 32'(vga_v_sync), 32'd1);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_cx", 32'(CounterX), 32'd0);
    check("rst_cy", 32'(CounterY), 32'd0);
    outQ.delete();
    ctrQ.delete();
    shBx = 0; shBy = 0;
    for (int i = 0; i < NP; i++) begin
      shPx[i] = 0; shGy[i] = 0; shEn[i] = 0;
    end
    repeat (3) @(negedge ClkPort);
    reset = 1'b1;
    k = 0;
    n = 0;
    idle.r = 0; idle.g = 0; idle.b = 0; idle.hs = 1; idle.vs = 1;
    outQ.push_back(idle);
    modelStep();
  endtask

  // Monitor: each time the pixel counter advances the DUT presents a new output.
  initial begin
    logic [9:0] prevX;
    ctrExp_t c;
    outExp_t o;
    string tag;
    prevX = '0;
    forever begin
      @(posedge ClkPort);
      #1;
      if (reset !== 1'b1) begin
        prevX = '0;
        continue;
      end
      if (CounterX !== prevX) begin
        if (ctrQ.size() == 0 || outQ.size() == 0) begin
          check("queue_underflow", 32'd1, 32'd0);
        end else begin
          c = ctrQ.pop_front();
          o = outQ.pop_front();
          tag = $sformatf("@(%0d,%0d)", c.x, c.y);
          check({"cx", tag}, 32'(CounterX), 32'(c.x));
          check({"cy", tag}, 32'(CounterY), 32'(c.y));
          check({"tick", tag}, 32'(frame_tick), 32'(c.tick));
          check({"rgb", tag}, 32'({vga_r, vga_g, vga_b}), 32'({o.r, o.g, o.b}));
          check({"hs", tag}, 32'(vga_h_sync), 32'(o.hs));
          check({"vs", tag}, 32'(vga_v_sync), 32'(o.vs));
        end
      end else begin
        check("tick_idle", 32'(frame_tick), 32'd0);
      end
      prevX = CounterX;
    end
  end

  initial begin
    #(40 * FRAME_CYC * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pipes enabled before reset must stay undrawn until the first frame tick.
    setScene(10, 5, 20, 8, 1, H_ACTIVE - 3, 2, 1, 0, 0, 0);
    #1;
    resetDut();
    runCycles(2 * FRAME_CYC, 0);

    // Bird overlapping pipe0, changed mid-frame; pipe1 at the right edge.
    runUntilLine(10);
    setScene(21, 2, 20, 8, 1, H_ACTIVE - 3, 2, 1, 30, 15, 1);
    runCycles(FRAME_CYC + FRAME_CYC / 2, 0);

    // Reset in the middle of the active area.
    runUntilLine(20);
    setScene(5, 18, 12, 3, 1, 33, 10, 1, 0, 0, 1);
    resetDut();
    runCycles(2 * FRAME_CYC, 0);

    // Random scenes changing at arbitrary points within frames.
    randScene();
    runCycles(4 * FRAME_CYC, 1);

    @(negedge ClkPort);
    check("queue_drain", 32'(ctrQ.size() <= 1 && outQ.size() <= 2), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
